// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: two-requester break-before-make arbiter driving a 74S157 mux bank's SEL/ENB_N
module mux_bus_arbiter #(
  parameter int SETTLE_CYC  = 1,
  parameter int MAX_HOLD    = 8,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic mux_sel,
  output logic mux_enb_n,
  output logic preempt
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYC - 1);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, OWN = 2'd2, RELEASE = 2'd3;
  logic [1:0] state, nxt;
  logic [HW-1:0] hold, hold_inc;
  logic [SW-1:0] scnt;
  logic last, pick, own_req, oth_req, pre_nxt;
  // mux_sel always names the current (or pending) owner, so owner/other requests are muxed by it
  always_comb begin
    own_req  = mux_sel ? req_b : req_a;
    oth_req  = mux_sel ? req_a : req_b;
    hold_inc = (hold == HMAX) ? hold : hold + 1'b1;
    pick     = (req_a && req_b) ? (ROUND_ROBIN && !last) : req_b;
    pre_nxt  = (state == OWN) && own_req && (MAX_HOLD != 0) && (hold_inc == HMAX) && oth_req;
    nxt      = state == IDLE   ? ((req_a || req_b) ? SETTLE : IDLE)
             : state == SETTLE ? (!own_req ? IDLE : (scnt == SMAX) ? OWN : SETTLE)
             : state == OWN    ? (!own_req ? IDLE : pre_nxt ? RELEASE : OWN)
             : IDLE;
  end
  // state, counters and registered outputs; SEL only loads on the IDLE->SETTLE edge while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mux_sel   <= 1'b0;
      last      <= 1'b1;
      hold      <= '0;
      scnt      <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      mux_enb_n <= 1'b1;
      preempt   <= 1'b0;
    end else begin
      state     <= nxt;
      mux_sel   <= (state == IDLE && nxt == SETTLE) ? pick : mux_sel;
      last      <= (state == SETTLE && nxt == OWN) ? mux_sel : last;
      hold      <= (state == OWN) ? hold_inc : '0;
      scnt      <= (state == SETTLE) ? scnt + 1'b1 : '0;
      gnt_a     <= (nxt == OWN) && !mux_sel;
      gnt_b     <= (nxt == OWN) && mux_sel;
      mux_enb_n <= nxt != OWN;
      preempt   <= pre_nxt;
    end
  end
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb_mux_bus_arbiter: three arbiter configurations on shared stimulus, checked by a queue scoreboard
module tb_mux_bus_arbiter;
  logic clk = 1'b0;
  logic reset, req_a, req_b;
  logic [2:0] gnt_a, gnt_b, mux_sel, mux_enb_n, preempt;
  int n_chk = 0, n_pass = 0;
  logic [4:0] q[3][$];
  logic rst_seen = 1'b0;
  int st[3] = '{1, 1, 2};
  int mh[3] = '{8, 0, 3};
  int rr[3] = '{1, 0, 1};
  int owner[3], pend[3], left[3], ten[3], cool[3], last[3], sel[3], pre[3];
  logic psel[3], pen[3];

  always #5 clk = ~clk;

  mux_bus_arbiter #(.SETTLE_CYC(1), .MAX_HOLD(8), .ROUND_ROBIN(1'b1)) u0 (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]),
    .mux_sel(mux_sel[0]), .mux_enb_n(mux_enb_n[0]), .preempt(preempt[0]));
  mux_bus_arbiter #(.SETTLE_CYC(1), .MAX_HOLD(0), .ROUND_ROBIN(1'b0)) u1 (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]),
    .mux_sel(mux_sel[1]), .mux_enb_n(mux_enb_n[1]), .preempt(preempt[1]));
  mux_bus_arbiter #(.SETTLE_CYC(2), .MAX_HOLD(3), .ROUND_ROBIN(1'b1)) u2 (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a[2]), .gnt_b(gnt_b[2]),
    .mux_sel(mux_sel[2]), .mux_enb_n(mux_enb_n[2]), .preempt(preempt[2]));

  // reference model: who owns the bus, who is waiting to settle in, and how long things have lasted
  always @(posedge clk) begin
    rst_seen = reset;
    for (int k = 0; k < 3; k++) begin
      int r[2];
      r[0] = int'(req_a);
      r[1] = int'(req_b);
      pre[k] = 0;
      if (reset) begin
        owner[k] = -1; pend[k] = -1; cool[k] = 0; last[k] = 1; sel[k] = 0; ten[k] = 0;
      end else if (owner[k] >= 0) begin
        if (r[owner[k]] == 0) owner[k] = -1;
        else begin
          ten[k] = (ten[k] + 1 > mh[k]) ? mh[k] : ten[k] + 1;
          if (mh[k] > 0 && ten[k] == mh[k] && r[1 - owner[k]] == 1) begin
            owner[k] = -1; cool[k] = 1; pre[k] = 1;
          end
        end
      end else if (pend[k] >= 0) begin
        if (r[pend[k]] == 0) pend[k] = -1;
        else begin
          left[k]--;
          if (left[k] == 0) begin
            owner[k] = pend[k]; last[k] = pend[k]; pend[k] = -1; ten[k] = 0;
          end
        end
      end else if (cool[k] != 0) cool[k] = 0;
      else if (r[0] + r[1] > 0) begin
        pend[k] = (r[0] == 1 && r[1] == 1) ? (rr[k] != 0 ? 1 - last[k] : 0) : r[1];
        sel[k] = pend[k];
        left[k] = st[k];
      end
      q[k].push_back({owner[k] == 0, owner[k] == 1, sel[k] == 1, owner[k] < 0, pre[k] == 1});
    end
  end

  // monitor: pop expected outputs and check bus-safety invariants half a cycle after each edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (q[k].size() > 0) begin
        logic [4:0] exp_v, act_v;
        logic inv;
        exp_v = q[k].pop_front();
        act_v = {gnt_a[k], gnt_b[k], mux_sel[k], mux_enb_n[k], preempt[k]};
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL outputs cfg%0d t=%0t got {ga,gb,sel,enb_n,pre}=%b want %b", k, $time, act_v, exp_v);
        inv = !(gnt_a[k] && gnt_b[k]) && (!gnt_a[k] || (!mux_enb_n[k] && !mux_sel[k]))
           && (!gnt_b[k] || (!mux_enb_n[k] && mux_sel[k])) && (mux_enb_n[k] || (gnt_a[k] ^ gnt_b[k]))
           && (mux_sel[k] == psel[k] || (pen[k] && mux_enb_n[k]) || rst_seen);
        n_chk++;
        if (inv === 1'b1) n_pass++;
        else $display("FAIL invariant cfg%0d t=%0t got 0 want 1 (ga=%b gb=%b sel=%b enb_n=%b prev_sel=%b prev_enb_n=%b)",
                      k, $time, gnt_a[k], gnt_b[k], mux_sel[k], mux_enb_n[k], psel[k], pen[k]);
        psel[k] = mux_sel[k];
        pen[k] = mux_enb_n[k];
      end
    end
  end

  task automatic drive(input logic a, input logic b, input logic r, input int n);
    repeat (n) begin
      @(negedge clk);
      req_a = a; req_b = b; reset = r;
    end
  endtask

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    for (int k = 0; k < 3; k++) begin psel[k] = 1'b0; pen[k] = 1'b1; end
    drive(0, 0, 1, 2);
    drive(1, 0, 0, 4);  drive(0, 0, 0, 3);
    drive(1, 1, 0, 5);  drive(0, 1, 0, 6);  drive(0, 0, 0, 3);
    drive(1, 0, 0, 3);  drive(1, 1, 0, 16); drive(0, 0, 0, 3);
    drive(0, 1, 0, 1);  drive(0, 0, 0, 4);
    drive(0, 1, 0, 5);  drive(0, 1, 1, 1);  drive(1, 1, 0, 5); drive(0, 0, 0, 3);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      reset = ($urandom_range(199) == 0);
    end
    drive(0, 0, 0, 3);
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (q[k].size() == 0) n_pass++;
      else $display("FAIL drain cfg%0d got %0d pending want 0", k, q[k].size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
